// File: rtl/parity_engine.sv
// parity_engine: parity generator plus serial parity checker.
// The generator is a one-deep registered stage with a valid/ready handshake.
// The checker receives DATA_W bits LSB first. When a parity mode is active it
// then receives one parity bit. It pulses Frame_Done at the end of a character,
// pulses Parity_Err on a mismatch, and keeps a saturating error count.
module parity_engine #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [2:0]           Mode,
  input  logic                 Gen_Valid,
  output logic                 Gen_Ready,
  input  logic [DATA_W-1:0]    Data_In,
  output logic                 Gen_Out_Valid,
  input  logic                 Gen_Out_Ready,
  output logic                 Parity_Bit,
  input  logic                 Chk_Start,
  input  logic                 Chk_Bit_Valid,
  input  logic                 Chk_Bit,
  output logic                 Chk_Busy,
  output logic                 Frame_Done,
  output logic                 Parity_Err,
  input  logic                 Err_Clr,
  output logic [ERR_CNT_W-1:0] Err_Count
);

  localparam int                   CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } chk_state_e;

  // Parity bit for a mode, given the XOR reduction of the data bits.
  function automatic logic parity_fn(input logic [2:0] mode, input logic xor_v);
    logic res;
    case (mode)
      3'b001:  res = xor_v;
      3'b010:  res = ~xor_v;
      3'b011:  res = 1'b1;
      3'b100:  res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // True when the mode sends a parity bit. None and reserved codes send no parity bit.
  function automatic logic mode_has_parity(input logic [2:0] mode);
    logic res;
    case (mode)
      3'b001, 3'b010, 3'b011, 3'b100: res = 1'b1;
      default:                        res = 1'b0;
    endcase
    return res;
  endfunction

  // ---------------- generator ----------------
  logic gen_out_valid_r;
  logic parity_bit_r;
  logic gen_ready_s;

  assign gen_ready_s   = !gen_out_valid_r || Gen_Out_Ready;
  assign Gen_Ready     = gen_ready_s;
  assign Gen_Out_Valid = gen_out_valid_r;
  assign Parity_Bit    = parity_bit_r;

  // Output stage of the generator. On accept it captures the result. While the
  // consumer stalls it holds the result. When the result is consumed and no new
  // word is accepted, it drains.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      gen_out_valid_r <= 1'b0;
      parity_bit_r    <= 1'b0;
    end else if (Gen_Valid && gen_ready_s) begin
      gen_out_valid_r <= 1'b1;
      parity_bit_r    <= parity_fn(Mode, ^Data_In);
    end else if (Gen_Out_Ready) begin
      gen_out_valid_r <= 1'b0;
    end
  end

  // ---------------- checker ----------------
  chk_state_e       state_r;
  chk_state_e       state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             acc_r;
  logic [2:0]       mode_r;
  logic             last_bit_s;
  logic             frame_done_s;
  logic             parity_err_s;
  logic             chk_busy_s;
  logic             frame_done_r;
  logic             parity_err_r;
  logic             chk_busy_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  assign last_bit_s = (bit_cnt_r == LAST_BIT);

  // Checker state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Checker next state. Chk_Start restarts from any state and wins over a bit
  // that arrives in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (Chk_Start) begin
      state_nxt_s = ST_DATA;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_DATA: begin
          if (Chk_Bit_Valid && last_bit_s) begin
            state_nxt_s = mode_has_parity(mode_r) ? ST_PARITY : ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (Chk_Bit_Valid) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PARITY;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Checker outputs for the next cycle. These are the end-of-character pulse,
  // the mismatch pulse and the busy flag.
  always_comb begin
    frame_done_s = 1'b0;
    parity_err_s = 1'b0;
    chk_busy_s   = (state_nxt_s != ST_IDLE);
    if (!Chk_Start && Chk_Bit_Valid) begin
      case (state_r)
        ST_DATA: begin
          frame_done_s = last_bit_s && !mode_has_parity(mode_r);
        end
        ST_PARITY: begin
          frame_done_s = 1'b1;
          parity_err_s = (Chk_Bit != parity_fn(mode_r, acc_r));
        end
        default: begin
          frame_done_s = 1'b0;
        end
      endcase
    end else begin
      frame_done_s = 1'b0;
    end
  end

  // Checker datapath. Start clears the counter and accumulator and latches the
  // mode for the character. Each data bit is folded into the accumulator.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_cnt_r <= {CNT_W{1'b0}};
      acc_r     <= 1'b0;
      mode_r    <= 3'b000;
    end else if (Chk_Start) begin
      bit_cnt_r <= {CNT_W{1'b0}};
      acc_r     <= 1'b0;
      mode_r    <= Mode;
    end else if (state_r == ST_DATA && Chk_Bit_Valid) begin
      bit_cnt_r <= bit_cnt_r + CNT_ONE;
      acc_r     <= acc_r ^ Chk_Bit;
    end
  end

  // Registered checker outputs. The error counter counts in the same cycle the
  // mismatch is detected, so a clear in that cycle leaves exactly one error.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      frame_done_r <= 1'b0;
      parity_err_r <= 1'b0;
      chk_busy_r   <= 1'b0;
      err_count_r  <= {ERR_CNT_W{1'b0}};
    end else begin
      frame_done_r <= frame_done_s;
      parity_err_r <= parity_err_s;
      chk_busy_r   <= chk_busy_s;
      if (Err_Clr) begin
        err_count_r <= parity_err_s ? ERR_ONE : {ERR_CNT_W{1'b0}};
      end else if (parity_err_s && err_count_r != ERR_MAX) begin
        err_count_r <= err_count_r + ERR_ONE;
      end
    end
  end

  assign Frame_Done = frame_done_r;
  assign Parity_Err = parity_err_r;
  assign Chk_Busy   = chk_busy_r;
  assign Err_Count  = err_count_r;

endmodule
